// File: rtl/seven_seg_pkg.sv
// Shared constants for the eight-digit seven-segment display path:
// geometry of the display, the blank segment pattern and the hex glyph table.
package seven_seg_pkg;

    localparam int SEG_WIDTH    = 7;
    localparam int DIGIT_COUNT  = 8;
    localparam int NIBBLE_WIDTH = 4;
    localparam int IDX_WIDTH    = $clog2(DIGIT_COUNT);

    // All segments off (segments are active-low).
    localparam logic [SEG_WIDTH-1:0] SEG_BLANK = 7'h7F;

    // Glyphs for 0..F, bit order {g,f,e,d,c,b,a}, active-low.
    localparam logic [SEG_WIDTH-1:0] HEX_SEG_TABLE [16] = '{
        7'b1000000,  // 0
        7'b1111001,  // 1
        7'b0100100,  // 2
        7'b0110000,  // 3
        7'b0011001,  // 4
        7'b0010010,  // 5
        7'b0000010,  // 6
        7'b1111000,  // 7
        7'b0000000,  // 8
        7'b0010000,  // 9
        7'b0001000,  // A
        7'b0000011,  // b
        7'b1000110,  // C
        7'b0100001,  // d
        7'b0000110,  // E
        7'b0001110   // F
    };

    typedef logic [IDX_WIDTH-1:0] digit_idx_t;

endpackage

// File: rtl/seven_seg_hex_decoder.sv
// Pure combinational nibble to active-low segment pattern decoder.
module seven_seg_hex_decoder
    import seven_seg_pkg::*;
(
    input  logic [NIBBLE_WIDTH-1:0] nibble,
    output logic [SEG_WIDTH-1:0]    seg_n
);

    // Straight lookup into the shared glyph table.
    assign seg_n = HEX_SEG_TABLE[nibble];

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed scan driver for the eight-digit seven-segment display.
// Register-file values are captured into shadow registers only at the frame
// wrap so a frame is always drawn from one consistent set of values.
// CLK_DIV must be a multiple of 16 and at least 32 so that each brightness
// step is a whole number of cycles.
module seven_seg_scan_driver
    import seven_seg_pkg::*;
#(
    parameter int CLK_DIV = 100000
) (
    input  logic        ACLK,
    input  logic        ARESET,
    input  logic [31:0] disp_data,
    input  logic [7:0]  disp_en,
    input  logic [7:0]  disp_dp,
    input  logic        blank_lz,
    input  logic [3:0]  brightness,
    input  logic        load,
    output logic        load_pending,
    output logic        frame_start,
    output logic [6:0]  seg_n,
    output logic        dp_n,
    output logic [7:0]  an_n
);

    localparam int SLICE     = CLK_DIV / 16;
    localparam int PRE_WIDTH = $clog2(CLK_DIV);
    localparam logic [PRE_WIDTH-1:0] PRE_LAST = PRE_WIDTH'(CLK_DIV - 1);
    localparam digit_idx_t IDX_LAST = digit_idx_t'(DIGIT_COUNT - 1);

    logic [PRE_WIDTH-1:0]    prescaler;
    digit_idx_t              idx;
    logic                    tick;
    logic                    wrap;

    logic [31:0]             shadow_data;
    logic [7:0]              shadow_en;
    logic [7:0]              shadow_dp;
    logic                    shadow_blank_lz;
    logic [3:0]              shadow_brightness;

    logic                    upper_zero;
    logic [DIGIT_COUNT-1:0]  visible;
    logic [PRE_WIDTH:0]      pwm_limit;
    logic                    in_window;
    logic                    lit;
    logic [NIBBLE_WIDTH-1:0] cur_nibble;
    logic [SEG_WIDTH-1:0]    cur_seg;

    assign tick = (prescaler == PRE_LAST);
    assign wrap = tick && (idx == IDX_LAST);

    // Slot prescaler and digit index; the index wraps 7 -> 0 by natural overflow.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            prescaler <= '0;
            idx       <= '0;
        end else if (tick) begin
            prescaler <= '0;
            idx       <= idx + digit_idx_t'(1);
        end else begin
            prescaler <= prescaler + PRE_WIDTH'(1);
        end
    end

    // Frame pulse, deferred-load flag and shadow capture at the frame wrap.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            frame_start       <= 1'b0;
            load_pending      <= 1'b0;
            shadow_data       <= '0;
            shadow_en         <= '0;
            shadow_dp         <= '0;
            shadow_blank_lz   <= 1'b0;
            shadow_brightness <= '0;
        end else begin
            frame_start <= wrap;
            if (wrap) begin
                load_pending <= 1'b0;
                if (load || load_pending) begin
                    shadow_data       <= disp_data;
                    shadow_en         <= disp_en;
                    shadow_dp         <= disp_dp;
                    shadow_blank_lz   <= blank_lz;
                    shadow_brightness <= brightness;
                end
            end else if (load) begin
                load_pending <= 1'b1;
            end
        end
    end

    // Per-digit visibility: walk from the top digit down, tracking whether every
    // nibble seen so far is zero; digit 0 is always allowed to show.
    always_comb begin
        upper_zero = 1'b1;
        visible    = '0;
        for (int i = DIGIT_COUNT - 1; i >= 0; i--) begin
            upper_zero = upper_zero &&
                         (shadow_data[i*NIBBLE_WIDTH +: NIBBLE_WIDTH] == '0);
            visible[i] = shadow_en[i] &&
                         !(shadow_blank_lz && upper_zero && (i != 0));
        end
    end

    // On-time window: prescaler 0 is the dead cycle that prevents ghosting
    // between adjacent digits.
    assign pwm_limit  = (PRE_WIDTH+1)'((32'(shadow_brightness) + 32'd1) * 32'(SLICE));
    assign in_window  = (prescaler != '0) && ({1'b0, prescaler} < pwm_limit);
    assign cur_nibble = shadow_data[int'(idx)*NIBBLE_WIDTH +: NIBBLE_WIDTH];
    assign lit        = in_window && visible[idx];

    seven_seg_hex_decoder u_hex_decoder (
        .nibble (cur_nibble),
        .seg_n  (cur_seg)
    );

    // Registered pin drive, one cycle behind the prescaler and index.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            an_n  <= 8'hFF;
            seg_n <= SEG_BLANK;
            dp_n  <= 1'b1;
        end else if (lit) begin
            an_n  <= ~(8'(1) << idx);
            seg_n <= cur_seg;
            dp_n  <= ~shadow_dp[idx];
        end else begin
            an_n  <= 8'hFF;
            seg_n <= SEG_BLANK;
            dp_n  <= 1'b1;
        end
    end

endmodule
